// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_arb_pkg
// Brief    : Shared widths and state encoding for the BRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

   localparam int c_ADDR_W_DEFAULT = 11;
   localparam int c_DATA_W_DEFAULT = 8;
   localparam int c_CNT_W          = 4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/bram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : bram_arb_pick
// Brief    : Combinational winner selection; round-robin when BRAM_ARB_RR_EN
//            is defined, fixed priority (req0 first) otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module bram_arb_pick (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_owner,
   input  logic i_cnt_expired,
   output logic o_winner
);

   logic w_owner_req;

   assign w_owner_req = i_owner ? i_req1 : i_req0;

   always_comb begin
      o_winner = i_owner;
      // An unexpired burst keeps the bus whenever its owner still asks.
      if (!i_cnt_expired && w_owner_req) begin
         o_winner = i_owner;
      end else if (i_req0 && i_req1) begin
`ifdef BRAM_ARB_RR_EN
         o_winner = ~i_owner;
`else
         o_winner = 1'b0;
`endif
      end else if (i_req0) begin
         o_winner = 1'b0;
      end else if (i_req1) begin
         o_winner = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Brief    : Shares one synchronous BRAM port between two requesters with
//            burst-limited grants. Define BRAM_ARB_RR_EN for round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W    = c_ADDR_W_DEFAULT,
   parameter int DATA_W    = c_DATA_W_DEFAULT,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic              i_we0,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_rvalid0,
   output logic              o_rvalid1,
   output logic [DATA_W-1:0] o_rdata0,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_data,
   output logic              o_ram_we,
   input  logic [DATA_W-1:0] i_ram_q,
   output logic              o_owner
);

   localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_BURST);

   arb_state_t         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_owner;
   logic               r_rvalid0;
   logic               r_rvalid1;
   logic [DATA_W-1:0]  r_rhold0;
   logic [DATA_W-1:0]  r_rhold1;

   logic w_any;
   logic w_cnt_expired;
   logic w_winner;
   logic w_continue;

   // Reset gates the grant so nothing reaches the BRAM while rst_n is low.
   assign w_any         = rst_n && (i_req0 || i_req1);
   assign w_cnt_expired = (r_state == ST_IDLE) || (r_cnt >= c_MAX);
   assign w_continue    = !w_cnt_expired && (w_winner == r_owner);

   bram_arb_pick u_pick (
      .i_req0        (i_req0),
      .i_req1        (i_req1),
      .i_owner       (r_owner),
      .i_cnt_expired (w_cnt_expired),
      .o_winner      (w_winner)
   );

   assign o_gnt0 = w_any && !w_winner;
   assign o_gnt1 = w_any &&  w_winner;

   always_comb begin
      o_ram_we   = 1'b0;
      o_ram_addr = '0;
      o_ram_data = '0;
      if (o_gnt0) begin
         o_ram_we   = i_we0;
         o_ram_addr = i_addr0;
         o_ram_data = i_wdata0;
      end else if (o_gnt1) begin
         o_ram_we   = i_we1;
         o_ram_addr = i_addr1;
         o_ram_data = i_wdata1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_owner   <= 1'b1;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         r_rhold0  <= '0;
         r_rhold1  <= '0;
      end else begin
         r_rvalid0 <= o_gnt0 && !i_we0;
         r_rvalid1 <= o_gnt1 && !i_we1;
         if (r_rvalid0) r_rhold0 <= i_ram_q;
         if (r_rvalid1) r_rhold1 <= i_ram_q;
         if (w_any) begin
            r_state <= ST_BUSY;
            r_owner <= w_winner;
            r_cnt   <= w_continue ? (r_cnt + 1'b1) : c_CNT_W'(1);
         end else begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end
      end
   end

   // BRAM output is live during the rvalid cycle; the hold register keeps it after.
   assign o_rvalid0 = r_rvalid0;
   assign o_rvalid1 = r_rvalid1;
   assign o_rdata0  = r_rvalid0 ? i_ram_q : r_rhold0;
   assign o_rdata1  = r_rvalid1 ? i_ram_q : r_rhold1;
   assign o_owner   = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Brief    : Scoreboard bench for bram_port_arbiter with a BRAM model and a
//            rule-level arbitration model (follows BRAM_ARB_RR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

   localparam int AW = 11;
   localparam int DW = 8;
   localparam int MB = 4;
`ifdef BRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct packed {
      logic          g0;
      logic          g1;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          own;
      logic          in_rst;
   } gexp_t;

   typedef struct packed {
      int            cyc;
      logic [DW-1:0] data;
   } rexp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, owner;
   logic [DW-1:0] rdata0, rdata1, ram_data;
   logic [DW-1:0] ram_q;
   logic [AW-1:0] ram_addr;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   gexp_t q_g[$];
   rexp_t q_r0[$];
   rexp_t q_r1[$];

   logic          a_rst_n;
   logic          a_req   [2];
   logic          a_we    [2];
   logic [AW-1:0] a_addr  [2];
   logic [DW-1:0] a_wdata [2];
   logic          m_owner;
   int            m_run;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] last_rd [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req0     (req0),
      .i_req1     (req1),
      .i_we0      (we0),
      .i_we1      (we1),
      .i_addr0    (addr0),
      .i_addr1    (addr1),
      .i_wdata0   (wdata0),
      .i_wdata1   (wdata1),
      .o_gnt0     (gnt0),
      .o_gnt1     (gnt1),
      .o_rvalid0  (rvalid0),
      .o_rvalid1  (rvalid1),
      .o_rdata0   (rdata0),
      .o_rdata1   (rdata1),
      .o_ram_addr (ram_addr),
      .o_ram_data (ram_data),
      .o_ram_we   (ram_we),
      .i_ram_q    (ram_q),
      .o_owner    (owner)
   );

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 5) return 8'h5A;
      return DW'((i * 37 + 11) ^ (i >> 3));
   endfunction

   // Synchronous single-port BRAM, read-first, preloaded on the first edge.
   logic [DW-1:0] bram [0:(1<<AW)-1];
   logic          loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < (1 << AW); i++) bram[i] <= init_val(i);
         loaded <= 1'b1;
      end else if (ram_we) begin
         bram[ram_addr] <= ram_data;
      end
      ram_q <= bram[ram_addr];
   end

   // One bus cycle: drive inputs, decide the expected grant from the rules, queue expectations.
   task automatic cycle_go();
      gexp_t g;
      rexp_t r;
      logic  w;
      logic  cont;
      int    wi;
      @(negedge clk);
      rst_n  = a_rst_n;
      req0   = a_req[0];   req1   = a_req[1];
      we0    = a_we[0];    we1    = a_we[1];
      addr0  = a_addr[0];  addr1  = a_addr[1];
      wdata0 = a_wdata[0]; wdata1 = a_wdata[1];
      g = '0;
      if (!a_rst_n) begin
         m_owner = 1'b1;
         m_run   = 0;
      end
      g.own    = m_owner;
      g.in_rst = !a_rst_n;
      if (a_rst_n && (a_req[0] || a_req[1])) begin
         cont = (m_run > 0) && (m_run < MB) && a_req[int'(m_owner)];
         if (cont)                      w = m_owner;
         else if (a_req[0] && a_req[1]) w = RR ? !m_owner : 1'b0;
         else                           w = !a_req[0];
         wi     = int'(w);
         g.g0   = !w;
         g.g1   = w;
         g.we   = a_we[wi];
         g.addr = a_addr[wi];
         g.data = a_wdata[wi];
         if (a_we[wi]) begin
            ref_mem[a_addr[wi]] = a_wdata[wi];
         end else begin
            r.cyc  = cyc + 1;
            r.data = ref_mem[a_addr[wi]];
            if (wi == 0) q_r0.push_back(r);
            else         q_r1.push_back(r);
         end
         m_run   = cont ? m_run + 1 : 1;
         m_owner = w;
         a_req[wi] = 1'b0;
      end else if (a_rst_n) begin
         m_run = 0;
      end
      q_g.push_back(g);
   endtask

   task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      a_req[p] = 1'b1; a_we[p] = we; a_addr[p] = a; a_wdata[p] = d;
   endtask

   task automatic rand_reqs(input int pct);
      for (int p = 0; p < 2; p++) begin
         if (!a_req[p] && ($urandom_range(0, 99) < pct)) begin
            set_req(p, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 15)),
                    DW'($urandom));
         end
      end
   endtask

   task automatic chk_rd(input int p, input logic rv, input logic [DW-1:0] rd);
      rexp_t e;
      logic  have;
      have = (p == 0) ? (q_r0.size() > 0) : (q_r1.size() > 0);
      e    = '0;
      if (have) e = (p == 0) ? q_r0[0] : q_r1[0];
      total++;
      if (rv) begin
         if (!have || e.cyc != cyc) begin
            bad++;
            $display("FAIL rvalid%0d cyc=%0d: got unexpected rvalid=1 rdata=%h, want rvalid=0", p, cyc, rd);
            last_rd[p] = rd;
         end else begin
            if (p == 0) void'(q_r0.pop_front());
            else        void'(q_r1.pop_front());
            if (rd !== e.data) begin
               bad++;
               $display("FAIL rdata%0d cyc=%0d: got %h want %h", p, cyc, rd, e.data);
            end
            last_rd[p] = e.data;
         end
      end else if (have && e.cyc <= cyc) begin
         bad++;
         $display("FAIL rvalid%0d cyc=%0d: got rvalid=0, want rvalid=1 rdata=%h", p, cyc, e.data);
         if (p == 0) void'(q_r0.pop_front());
         else        void'(q_r1.pop_front());
      end else if (rd !== last_rd[p]) begin
         bad++;
         $display("FAIL rdata%0d_hold cyc=%0d: got %h want %h", p, cyc, rd, last_rd[p]);
      end
   endtask

   // Monitor: checks every cycle a little after the drive point.
   initial begin
      gexp_t g;
      last_rd[0] = '0;
      last_rd[1] = '0;
      forever begin
         @(negedge clk);
         #2;
         if (q_g.size() > 0) begin
            g = q_g.pop_front();
            total++;
            if (gnt0 !== g.g0 || gnt1 !== g.g1 || ram_we !== g.we || ram_addr !== g.addr ||
                ram_data !== g.data || owner !== g.own) begin
               bad++;
               $display("FAIL grant cyc=%0d: got g0=%b g1=%b we=%b addr=%h data=%h own=%b want g0=%b g1=%b we=%b addr=%h data=%h own=%b",
                        cyc, gnt0, gnt1, ram_we, ram_addr, ram_data, owner,
                        g.g0, g.g1, g.we, g.addr, g.data, g.own);
            end
            if (g.in_rst) begin
               last_rd[0] = '0;
               last_rd[1] = '0;
            end
         end
         chk_rd(0, rvalid0, rdata0);
         chk_rd(1, rvalid1, rdata1);
      end
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
      m_owner = 1'b1;
      m_run   = 0;
      a_rst_n = 1'b0;
      set_req(0, 1'b0, 11'd0, 8'h00);
      set_req(1, 1'b0, 11'd1, 8'h00);

      // Reset held with both requesting, then both held through two bursts.
      repeat (3) cycle_go();
      a_rst_n = 1'b1;
      repeat (12) begin
         cycle_go();
         a_req[0] = 1'b1;
         a_req[1] = 1'b1;
      end
      a_req[0] = 1'b0;
      a_req[1] = 1'b0;
      repeat (3) cycle_go();

      // Lone read of the preloaded word.
      set_req(0, 1'b0, 11'h005, 8'h00);
      repeat (3) cycle_go();

      // Write by one requester, read back by the other on the next cycle.
      set_req(0, 1'b1, 11'h7FF, 8'hC3);
      cycle_go();
      set_req(1, 1'b0, 11'h7FF, 8'h00);
      repeat (3) cycle_go();

      // Single read then drop with the other requester waiting.
      set_req(0, 1'b0, 11'h003, 8'h00);
      set_req(1, 1'b0, 11'h004, 8'h00);
      repeat (3) cycle_go();

      // Idle stretch.
      repeat (10) cycle_go();

      // Random traffic, heavy then light.
      repeat (800) begin rand_reqs(70); cycle_go(); end
      repeat (700) begin rand_reqs(25); cycle_go(); end
      for (int k = 0; k < 40 && (a_req[0] || a_req[1]); k++) cycle_go();
      repeat (3) cycle_go();

      // Reset arriving right after a granted read must swallow the response.
      set_req(0, 1'b0, 11'h005, 8'h00);
      cycle_go();
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      a_rst_n = 1'b0;
      q_r0.delete();
      q_r1.delete();
      m_owner = 1'b1;
      m_run   = 0;
      repeat (3) cycle_go();
      a_rst_n = 1'b1;
      repeat (6) cycle_go();

      repeat (2) @(negedge clk);
      #3;
      total++;
      if (q_g.size() != 0 || q_r0.size() != 0 || q_r1.size() != 0) begin
         bad++;
         $display("FAIL drain: got pending g=%0d r0=%0d r1=%0d want 0 0 0", q_g.size(), q_r0.size(), q_r1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, BRAM word address width (2K x 8 block).
REQ-002 Parameter DATA_W, default 8, BRAM data width.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one requester; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req0/req1  in  1 each  transfer request; held with payload stable until granted.
REQ-007 we0/we1  in  1 each  1 = write, 0 = read.
REQ-008 addr0/addr1  in  ADDR_W each  word address.
REQ-009 wdata0/wdata1  in  DATA_W each  write data.
REQ-010 gnt0/gnt1  out  1 each  transfer accepted this cycle (combinational from req and state).
REQ-011 rvalid0/rvalid1  out  1 each  read data valid, one cycle after a granted read.
REQ-012 rdata0/rdata1  out  DATA_W each  read data.
REQ-013 ram_addr/ram_data/ram_we  out  ADDR_W/DATA_W/1  drive one synchronous BRAM port.
REQ-014 ram_q  in  DATA_W  BRAM port output, valid one cycle after address presented.
REQ-015 owner  out  1  index of last granted requester.

Function
REQ-016 SHALL grant at most one requester per cycle; each grant cycle is exactly one BRAM access.
REQ-017 SHALL drive ram_addr/ram_data/ram_we from the granted requester's addr/wdata/we in the grant cycle.
REQ-018 With no grant, SHALL drive ram_we=0, ram_addr=0, ram_data=0.
REQ-019 States: IDLE (no owner), BUSY (owner plus beat counter cnt, 1..MAX_BURST).
REQ-020 IDLE: no req -> stay IDLE; any req -> grant the winner (REQ-027/028), go BUSY, cnt=1.
REQ-021 BUSY: owner req and cnt<MAX_BURST -> grant owner, cnt+1.
REQ-022 BUSY: owner req deasserted or cnt==MAX_BURST, other req asserted -> grant other, owner=other, cnt=1.
REQ-023 BUSY: cnt==MAX_BURST, only owner requesting -> grant owner, cnt=1.
REQ-024 BUSY: no req -> no grant, go IDLE.
REQ-025 Granted read SHALL assert that requester's rvalid in the next cycle, for exactly one cycle, with rdata=ram_q; rdata holds its value otherwise.
REQ-026 Granted write SHALL never raise rvalid; back-to-back write/read to one address by either requester SHALL return the new data.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, cnt=0, owner=1, gnt*=0, rvalid*=0, rdata*=0, ram_we=0.
REQ-030 Read pending at reset SHALL be dropped (no rvalid after deassertion); first grant no earlier than first rising edge with rst_n high.

Configuration
REQ-027 BRAM_ARB_RR_EN defined: at each decision point (IDLE or REQ-022/023 handoff with both requesting), winner is the requester that is not owner; cnt==MAX_BURST with both requesting SHALL hand off.
REQ-028 BRAM_ARB_RR_EN undefined: fixed priority, req0 wins every decision point; req1 may starve; burst counter still runs, owner update unchanged.

Structure
REQ-031 Package bram_arb_pkg SHALL hold ADDR_W/DATA_W defaults, state enum (IDLE, BUSY), and beat-counter width constant (4).
REQ-032 Sub-module bram_arb_pick SHALL hold winner selection (combinational; inputs req0, req1, owner, cnt_expired; output winner).

Verification
REQ-033 Preload 0x005=0x5A; req0 read 0x005 alone -> gnt0 cycle N, rvalid0 and rdata0=0x5A cycle N+1.
REQ-034 Both req held from reset, MAX_BURST=4, RR on -> grants 0,0,0,0,1,1,1,1,0...; RR off -> gnt0 every cycle, gnt1 never.
REQ-035 req0 write 0x7FF=0xC3 cycle N, req1 read 0x7FF cycle N+1 -> rdata1=0xC3 at N+2.
REQ-036 req0 one read then drop, req1 pending -> gnt1 the next cycle, cnt=1, owner=1.
REQ-037 rst_n low in cycle after granted read -> rvalid0 never asserts; all outputs 0 during reset.
REQ-038 No requests for 10 cycles -> ram_we=0, gnt0=gnt1=0, state IDLE throughout.
